resend_sched: RTL
=================

Name: resend_sched

Overview:
- Scheduler in front of the scrambling dispatcher: sequences the order IDs that the dispatcher transmits.
- Normally forwards fresh order IDs from the upstream source.
- When the dispatcher raises a resend request, queues the ID, enforces a holdoff gap, then replays queued IDs with priority.
- Guarantees fresh traffic one slot after every MAX_BURST consecutive replays, so it is never starved.

Parameters:
ID_W, 4, order ID width
FIFO_DEPTH, 4, pending-resend queue entries (power of 2, >=2)
HOLDOFF, 8, idle cycles between first resend capture and first replay (>=1)
MAX_BURST, 2, consecutive replays before one fresh grant is forced (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
new_vld  input  1  fresh order request valid
new_id  input  ID_W  fresh order ID
new_rdy  output  1  fresh request accepted when new_vld&&new_rdy
resend_en  input  1  resend request from dispatcher, single-cycle pulse
resend_id  input  ID_W  order ID to resend
issue_vld  output  1  order ID presented to dispatcher
issue_id  output  ID_W  order ID issued
issue_resend  output  1  1 = issued ID is a replay
issue_rdy  input  1  dispatcher accepts; handshake = issue_vld&&issue_rdy
pend_cnt  output  clog2(FIFO_DEPTH+1)  queued resend entries
ovf  output  1  sticky: a resend request was dropped because the queue was full

Behaviour:
- Reset (async, rst=1): state NORM, queue empty, holdoff counter 0, burst counter 0, ovf 0. While rst=1, issue_vld=0, new_rdy=0, issue_resend=0, issue_id=0, pend_cnt=0.
- Queue push: on resend_en when the queue is not full, or when it is full but a pop happens in the same cycle. The entry is visible in pend_cnt the next cycle.
- Duplicate drop: if resend_id equals a valid entry (excluding one popped that cycle), no push and no ovf.
- Full drop: resend_en while full with no pop: request dropped; ovf=1 from the next cycle until reset.
- Pop: queue head pops on a handshake in REPLAY. Simultaneous push and pop keeps the count unchanged.
- State NORM:
  - issue_vld=new_vld, issue_id=new_id, issue_resend=0, new_rdy=issue_rdy (combinational pass-through).
  - If the queue is non-empty or a push occurs: next state HOLD, counter=HOLDOFF-1.
  - A fresh handshake in that same cycle still completes.
- State HOLD:
  - issue_vld=0, new_rdy=0.
  - If counter==0, go to REPLAY; else decrement.
  - HOLD therefore lasts exactly HOLDOFF cycles.
  - Resends arriving during HOLD are queued; the counter is not restarted.
- State REPLAY:
  - issue_vld=1, issue_id=queue head, issue_resend=1, new_rdy=0.
  - issue_id stays stable while waiting for issue_rdy.
  - On handshake: pop and increment the burst counter.
  - After a handshake: if the queue becomes empty (no concurrent push), go to NORM and clear the burst counter. Otherwise, if burst==MAX_BURST and new_vld=1, go to FAIR. Otherwise stay in REPLAY.
  - The burst counter saturates at MAX_BURST while new_vld=0.
- State FAIR:
  - Same pass-through as NORM.
  - On a fresh handshake: clear the burst counter, then go to REPLAY if the queue is non-empty, else NORM.
  - If new_vld drops before a handshake: go to REPLAY (or NORM if empty), burst counter cleared.
- Replay latency: resend_en in cycle T while NORM with empty queue gives first replay issue_vld in cycle T+HOLDOFF+1.
- Resends arriving in REPLAY or FAIR are queued without a new holdoff.
- issue_rdy low stalls any state's handshake; no state advances on a missing handshake except HOLD counting and FAIR exit on new_vld low.
- Reset asserted mid-replay discards the queue; no partial state survives.

Test Plan:
- Reset, then new_vld=1 with IDs 1,2,3 and issue_rdy=1 -> issued 1,2,3 on consecutive cycles, issue_resend=0, pend_cnt=0.
- resend_en with id=5 at cycle T (HOLDOFF=8) -> new_rdy=0 for T+1..T+8; cycle T+9: issue_vld=1, issue_id=5, issue_resend=1; then state NORM, pend_cnt=0.
- Push IDs 7,8,9 and hold new_vld=1 (MAX_BURST=2) -> issue order 7R, 8R, fresh, 9R, then fresh traffic resumes.
- Push 1,2,3,4 then 5 with no pop -> pend_cnt=4, 5 dropped, ovf=1 and stays 1; push of duplicate 3 -> no change, ovf unaffected by the duplicate.
- In REPLAY with issue_rdy=0 for 5 cycles -> issue_id constant at the head and pend_cnt constant; then issue_rdy=1 -> one pop per cycle.
- Assert rst during REPLAY with 3 entries queued -> outputs go to 0 immediately, pend_cnt=0; after release, fresh traffic passes in NORM.

Source files
------------

// File: rtl/resend_sched.sv
// rtl/resend_sched.sv - Order ID scheduler: fresh pass-through, queued resend replay with holdoff and fairness.
module resend_sched #(
    parameter int ID_W       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLDOFF    = 8,
    parameter int MAX_BURST  = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              new_vld,
    input  logic [ID_W-1:0]                   new_id,
    output logic                              new_rdy,
    input  logic                              resend_en,
    input  logic [ID_W-1:0]                   resend_id,
    output logic                              issue_vld,
    output logic [ID_W-1:0]                   issue_id,
    output logic                              issue_resend,
    input  logic                              issue_rdy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   pend_cnt,
    output logic                              ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int HW = $clog2(HOLDOFF+1);
    localparam int BW = $clog2(MAX_BURST+1);

    typedef enum logic [1:0] {S_NORM, S_HOLD, S_REPLAY, S_FAIR} state_t;

    state_t                state_q, state_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [BW-1:0]         burst_q, burst_d, burst_inc;
    logic [PW-1:0]         rd_q, wr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [FIFO_DEPTH-1:0] vld_q;
    logic [ID_W-1:0]       mem_q [FIFO_DEPTH];
    logic                  ovf_q;
    logic                  full, pop, push, dup, drop;

    // Queue control; the entry popped this cycle cannot block a re-push of the same ID.
    always_comb begin
        full = (count_q == CW'(FIFO_DEPTH));
        pop  = (state_q == S_REPLAY) && issue_rdy;
        dup  = 1'b0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            if (vld_q[j] && (mem_q[j] == resend_id) && !(pop && (rd_q == PW'(j))))
                dup = 1'b1;
        end
        push    = resend_en && !dup && (!full || pop);
        drop    = resend_en && !dup && full && !pop;
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    // A push into the slot being popped (full queue) must win, so it is written last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            vld_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (pop) begin
                vld_q[rd_q] <= 1'b0;
                rd_q        <= rd_q + PW'(1);
            end
            if (push) begin
                vld_q[wr_q] <= 1'b1;
                wr_q        <= wr_q + PW'(1);
            end
            count_q <= count_d;
            if (drop)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= resend_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_NORM;
            hold_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        burst_d   = burst_q;
        burst_inc = (burst_q == BW'(MAX_BURST)) ? burst_q : burst_q + BW'(1);
        case (state_q)
            S_NORM: begin
                if ((count_q != '0) || push) begin
                    state_d = S_HOLD;
                    hold_d  = HW'(HOLDOFF - 1);
                end
            end
            S_HOLD: begin
                if (hold_q == '0)
                    state_d = S_REPLAY;
                else
                    hold_d = hold_q - HW'(1);
            end
            S_REPLAY: begin
                if (pop) begin
                    burst_d = burst_inc;
                    if (count_d == '0) begin
                        state_d = S_NORM;
                        burst_d = '0;
                    end else if ((burst_inc == BW'(MAX_BURST)) && new_vld) begin
                        state_d = S_FAIR;
                    end
                end
            end
            S_FAIR: begin
                if (!new_vld || issue_rdy) begin
                    burst_d = '0;
                    state_d = (count_d != '0) ? S_REPLAY : S_NORM;
                end
            end
            default: state_d = S_NORM;
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    always_comb begin
        issue_vld    = 1'b0;
        issue_id     = '0;
        issue_resend = 1'b0;
        new_rdy      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_NORM, S_FAIR: begin
                    issue_vld = new_vld;
                    issue_id  = new_id;
                    new_rdy   = issue_rdy;
                end
                S_REPLAY: begin
                    issue_vld    = 1'b1;
                    issue_id     = mem_q[rd_q];
                    issue_resend = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pend_cnt = count_q;
    assign ovf      = ovf_q;

endmodule
